// File: rtl/somador_pkg.sv
// Shared types and elaboration helpers for the sequential slice adder.
package somador_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  function automatic int unsigned nslice(input int unsigned width, input int unsigned slice);
    return width / slice;
  endfunction

  // Slice counter width; never below one bit even when a single slice covers the word.
  function automatic int unsigned cnt_width(input int unsigned width, input int unsigned slice);
    int unsigned n;
    n = nslice(width, slice);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/somador_fatia.sv
// Combinational SLICE-bit ripple adder; also exposes the carry into its top bit.
module somador_fatia #(
  parameter int unsigned SLICE = 1
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [SLICE:0] w_c;

  always_comb begin
    w_c    = '0;
    s      = '0;
    w_c[0] = cin;
    for (int i = 0; i < SLICE; i++) begin
      s[i]     = a[i] ^ b[i] ^ w_c[i];
      w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = w_c[SLICE];
  assign c_msb = w_c[SLICE-1];

endmodule

// File: rtl/somador_sequencial.sv
// Multi-cycle adder/subtractor: SLICE bits per clock, LSB first, start/busy/done handshake.
module somador_sequencial
  import somador_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SLICE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             Zero,
  output logic             busy,
  output logic             done
);

  localparam int unsigned NSLICE = nslice(WIDTH, SLICE);
  localparam int unsigned CNT_W  = cnt_width(WIDTH, SLICE);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

  if ((SLICE == 0) || (WIDTH < 2) || ((WIDTH % SLICE) != 0)) begin : g_bad_params
    $error("somador_sequencial: WIDTH must be >= 2 and a multiple of SLICE");
  end

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_part;
  logic             r_c;

  logic [SLICE-1:0] w_s;
  logic             w_cout;
  logic             w_cmsb;
  logic [WIDTH-1:0] w_part_nxt;

  somador_fatia #(
    .SLICE(SLICE)
  ) u_fatia (
    .a    (r_a[SLICE-1:0]),
    .b    (r_b[SLICE-1:0]),
    .cin  (r_c),
    .s    (w_s),
    .cout (w_cout),
    .c_msb(w_cmsb)
  );

  // New slice enters at the top, so after NSLICE shifts the word is in place.
  assign w_part_nxt = (r_part >> SLICE) | (WIDTH'(w_s) << (WIDTH - SLICE));
  assign busy       = (r_state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_part  <= '0;
      r_c     <= 1'b0;
      Sum     <= '0;
      Cout    <= 1'b0;
      Ovf     <= 1'b0;
      Zero    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= A;
            r_b     <= Sub ? ~B : B;
            r_c     <= Sub | Cin;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a    <= r_a >> SLICE;
          r_b    <= r_b >> SLICE;
          r_c    <= w_cout;
          r_part <= w_part_nxt;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            Sum     <= w_part_nxt;
            Cout    <= w_cout;
            Ovf     <= w_cmsb ^ w_cout;
            Zero    <= (w_part_nxt == '0);
            done    <= 1'b1;
            r_cnt   <= '0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_somador_sequencial.sv
// Bench for somador_sequencial: directed flag/handshake/reset cases plus random ops on three
// parameterisations, checked against a plain-arithmetic reference model.
module tb_somador_sequencial;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: WIDTH=8 SLICE=1, instance 1: WIDTH=16 SLICE=4, instance 2: WIDTH=8 SLICE=8
  logic [7:0]  a0 = '0, b0 = '0, s0;
  logic [15:0] a1 = '0, b1 = '0, s1;
  logic [7:0]  a2 = '0, b2 = '0, s2;
  logic c0 = 0, u0 = 0, st0 = 0, co0, ov0, z0, bz0, dn0;
  logic c1 = 0, u1 = 0, st1 = 0, co1, ov1, z1, bz1, dn1;
  logic c2 = 0, u2 = 0, st2 = 0, co2, ov2, z2, bz2, dn2;

  somador_sequencial #(.WIDTH(8), .SLICE(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(st0), .A(a0), .B(b0), .Cin(c0), .Sub(u0),
    .Sum(s0), .Cout(co0), .Ovf(ov0), .Zero(z0), .busy(bz0), .done(dn0)
  );
  somador_sequencial #(.WIDTH(16), .SLICE(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .A(a1), .B(b1), .Cin(c1), .Sub(u1),
    .Sum(s1), .Cout(co1), .Ovf(ov1), .Zero(z1), .busy(bz1), .done(dn1)
  );
  somador_sequencial #(.WIDTH(8), .SLICE(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(st2), .A(a2), .B(b2), .Cin(c2), .Sub(u2),
    .Sum(s2), .Cout(co2), .Ovf(ov2), .Zero(z2), .busy(bz2), .done(dn2)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int wid(input int sel);
    return (sel == 1) ? 16 : 8;
  endfunction

  function automatic int nsl(input int sel);
    return (sel == 0) ? 8 : ((sel == 1) ? 4 : 1);
  endfunction

  // Reference: unsigned sum for Sum/Cout, signed range test for overflow.
  function automatic void model(input int w, input longint a, input longint b, input bit cin,
                                input bit sub, output longint s, output bit co, output bit ov,
                                output bit z);
    longint mask, half, bop, c, u, sa, sb, sr;
    mask = (64'sd1 <<< w) - 1;
    half = 64'sd1 <<< (w - 1);
    bop  = sub ? (~b & mask) : b;
    c    = sub ? 1 : longint'(cin);
    u    = a + bop + c;
    s    = u & mask;
    co   = ((u >>> w) & 1) != 0;
    sa   = (a >= half) ? a - (mask + 1) : a;
    sb   = (bop >= half) ? bop - (mask + 1) : bop;
    sr   = sa + sb + c;
    ov   = (sr > half - 1) || (sr < -half);
    z    = (s == 0);
  endfunction

  task automatic drive(input int sel, input longint a, input longint b, input bit cin,
                       input bit sub, input bit st);
    case (sel)
      0: begin a0 = a[7:0];  b0 = b[7:0];  c0 = cin; u0 = sub; st0 = st; end
      1: begin a1 = a[15:0]; b1 = b[15:0]; c1 = cin; u1 = sub; st1 = st; end
      default: begin a2 = a[7:0]; b2 = b[7:0]; c2 = cin; u2 = sub; st2 = st; end
    endcase
  endtask

  task automatic sample(input int sel, output logic [63:0] s, output logic co, output logic ov,
                        output logic z, output logic bz, output logic dn);
    case (sel)
      0: begin s = 64'(s0); co = co0; ov = ov0; z = z0; bz = bz0; dn = dn0; end
      1: begin s = 64'(s1); co = co1; ov = ov1; z = z1; bz = bz1; dn = dn1; end
      default: begin s = 64'(s2); co = co2; ov = ov2; z = z2; bz = bz2; dn = dn2; end
    endcase
  endtask

  // One-cycle start pulse, then operands scrambled to show RUN ignores them.
  task automatic issue(input int sel, input longint a, input longint b, input bit cin,
                       input bit sub);
    @(negedge clk);
    drive(sel, a, b, cin, sub, 1'b1);
    @(negedge clk);
    drive(sel, longint'($urandom), longint'($urandom), 1'($urandom), 1'($urandom), 1'b0);
  endtask

  task automatic finish_op(input int sel, input string tag, input longint es, input bit ec,
                           input bit eo, input bit ez);
    logic [63:0] s;
    logic co, ov, z, bz, dn;
    int n = 0;
    sample(sel, s, co, ov, z, bz, dn);
    chk({tag, "_busy"}, 64'(bz), 64'd1);
    while (!dn && n < 40) begin
      @(negedge clk);
      n++;
      sample(sel, s, co, ov, z, bz, dn);
    end
    chk({tag, "_lat"}, 64'(n), 64'(nsl(sel)));
    chk({tag, "_sum"}, s, 64'(es));
    chk({tag, "_cout"}, 64'(co), 64'(ec));
    chk({tag, "_ovf"}, 64'(ov), 64'(eo));
    chk({tag, "_zero"}, 64'(z), 64'(ez));
  endtask

  task automatic run(input int sel, input string tag, input longint a, input longint b,
                     input bit cin, input bit sub, input longint es, input bit ec, input bit eo,
                     input bit ez);
    issue(sel, a, b, cin, sub);
    finish_op(sel, tag, es, ec, eo, ez);
  endtask

  initial begin
    longint es, ra, rb;
    bit ec, eo, ez, rc, ru;
    int n, seen;

    #1;
    chk("rst_sum0", 64'(s0), 64'd0);
    chk("rst_flags0", 64'({co0, ov0, z0, bz0, dn0}), 64'd0);
    chk("rst_sum1", 64'(s1), 64'd0);
    chk("rst_flags2", 64'({co2, ov2, z2, bz2, dn2}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run(0, "ff_plus_1", 'hFF, 'h01, 0, 0, 'h00, 1, 0, 1);
    run(0, "7f_plus_1", 'h7F, 'h01, 0, 0, 'h80, 0, 1, 0);
    run(0, "80_minus_1", 'h80, 'h01, 0, 1, 'h7F, 1, 1, 0);
    run(0, "00_minus_1", 'h00, 'h01, 0, 1, 'hFF, 0, 0, 0);
    run(0, "80_minus_1_cin", 'h80, 'h01, 1, 1, 'h7F, 1, 1, 0);
    run(0, "00_minus_1_cin", 'h00, 'h01, 1, 1, 'hFF, 0, 0, 0);
    run(0, "add_cin", 'h10, 'h05, 1, 0, 'h16, 0, 0, 0);

    // Abandon an op at its 4th RUN cycle: outputs clear at once and no done follows.
    issue(0, 'h33, 'h44, 0, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_sum", 64'(s0), 64'd0);
    chk("midrst_flags", 64'({co0, ov0, z0, bz0, dn0}), 64'd0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (dn0) seen = 1;
    end
    chk("midrst_no_done", 64'(seen), 64'd0);
    rst_n = 1'b1;
    run(0, "after_rst", 'h10, 'h20, 0, 0, 'h30, 0, 0, 0);

    // Start pulse at RUN cycle 3 is ignored; Sum holds until done.
    issue(0, 'h05, 'h03, 0, 0);
    n = 0;
    while (!dn0 && n < 40) begin
      if (n == 2) drive(0, 'hFF, 'hFF, 1, 0, 1'b1);
      else st0 = 1'b0;
      chk("hs_sum_hold", 64'(s0), 64'h30);
      @(negedge clk);
      n++;
    end
    chk("hs_lat1", 64'(n), 64'd8);
    chk("hs_sum1", 64'(s0), 64'h08);
    // Start on the done cycle is accepted.
    drive(0, 'h20, 'h22, 0, 0, 1'b1);
    @(negedge clk);
    drive(0, 'h77, 'h11, 0, 0, 1'b0);
    chk("hs_done_pulse", 64'(dn0), 64'd0);
    finish_op(0, "hs_b2b", 'h42, 0, 0, 0);

    run(1, "w16_7fff", 'h7FFF, 'h0001, 0, 0, 'h8000, 0, 1, 0);
    run(1, "w16_sub", 'h0000, 'h0001, 0, 1, 'hFFFF, 0, 0, 0);
    run(2, "w8s8_add", 'h12, 'h34, 0, 0, 'h46, 0, 0, 0);
    run(2, "w8s8_sub", 'h05, 'h05, 1, 1, 'h00, 1, 0, 1);

    for (int sel = 0; sel < 3; sel++) begin
      for (int i = 0; i < 3400; i++) begin
        ra = longint'($urandom) & ((64'sd1 <<< wid(sel)) - 1);
        rb = longint'($urandom) & ((64'sd1 <<< wid(sel)) - 1);
        rc = 1'($urandom);
        ru = 1'($urandom);
        model(wid(sel), ra, rb, rc, ru, es, ec, eo, ez);
        run(sel, "rand", ra, rb, rc, ru, es, ec, eo, ez);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/somador_sequencial.md
Name: somador_sequencial

Overview:
- Parametrised multi-cycle adder/subtractor. Successor to the 8-bit combinational ripple adder in the ULA project.
- Processes operands SLICE bits per clock, LSB slice first, with a start/busy/done handshake.
- Provides add/subtract mode plus Cout, signed-overflow and zero flags.
- Sits between the ULA control FSM and the result register.

Parameters:
- WIDTH, 8, operand and result width in bits; must be at least 2.
- SLICE, 1, bits processed per cycle; WIDTH % SLICE == 0 is required, and elaboration fails otherwise.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a new operation; sampled only when busy=0.
- A  in  WIDTH  operand A; latched on the accepted start.
- B  in  WIDTH  operand B; latched on the accepted start.
- Cin  in  1  carry-in for add; latched on start and ignored when Sub=1.
- Sub  in  1  0: A+B+Cin; 1: A-B, computed as A+~B+1; latched on start.
- Sum  out  WIDTH  result; updates only at completion.
- Cout  out  1  carry-out; in subtract mode, 1 means no borrow.
- Ovf  out  1  signed overflow, defined as carry into MSB XOR carry out of MSB.
- Zero  out  1  1 when the completed Sum == 0.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when the result is valid.

Behaviour:
- Reset (asynchronous, takes effect immediately, at any time):
  - Sum=0, Cout=0, Ovf=0, Zero=0, busy=0, done=0.
  - State returns to IDLE, slice counter=0, internal operand/partial registers=0.
  - Any in-flight operation is abandoned; no done is produced for it.
- Constant NSLICE = WIDTH/SLICE.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
- IDLE -> RUN at the edge where start=1:
  - Latches A, B (or ~B if Sub=1), carry (Cin, or 1 if Sub=1), and Sub.
  - Clears the slice counter.
  - busy goes high in the following cycle.
- RUN, one slice per edge:
  - Each edge adds slice i of A and B with the running carry.
  - Writes the slice into the internal partial-sum shift register.
  - Stores the carry-out as the next running carry and increments the counter.
- Final slice (counter == NSLICE-1):
  - At that edge: Sum <= completed partial; Cout <= final carry; Ovf <= carry_into_msb ^ carry_out; Zero <= (completed partial == 0).
  - At the same edge: done <= 1, busy <= 0, state -> IDLE.
- Latency: start sampled at edge k -> done high in the cycle after edge k+NSLICE. Busy occupies NSLICE cycles.
- done is high for exactly one cycle.
- Sum/Cout/Ovf/Zero hold their values until the next operation completes. They do not change during RUN.
- start while busy=1 is ignored, and operand changes during RUN have no effect.
- start during the done cycle is accepted, since state is IDLE. This gives back-to-back throughput of one result per NSLICE+1 cycles.
- SLICE == WIDTH: NSLICE=1, so the result arrives one cycle after start.
- Width rule: the internal carry chain is 1 bit. Sum wraps modulo 2^WIDTH, and the true result is {Cout,Sum} in add mode.

Decomposition:
- Package somador_pkg holds:
  - The state enum {IDLE, RUN}.
  - A function nslice(WIDTH,SLICE).
  - A counter-width function clog2(nslice), minimum 1.
- One sub-module, somador_fatia: a combinational SLICE-bit ripple adder.
  - Inputs: a, b, cin.
  - Outputs: s, cout, and c_msb (carry into the slice's top bit).
  - c_msb is used for Ovf on the final slice.
- The top level holds the FSM, counter, operand shift registers and result registers.

Test Plan:
- Reset/exhaustive: rst_n=0 -> all outputs 0. Then, with WIDTH=8 and SLICE=1, drive all 256x256 A,B with Cin=0 and Sub=0 -> {Cout,Sum} == A+B at each done, and done exactly 8 cycles after each accepted start.
- Flags: A=8'hFF, B=8'h01, add -> Sum=8'h00, Cout=1, Zero=1, Ovf=0. A=8'h7F, B=8'h01 -> Sum=8'h80, Cout=0, Ovf=1, Zero=0.
- Subtract: A=8'h80, B=8'h01, Sub=1 -> Sum=8'h7F, Cout=1, Ovf=1. A=8'h00, B=8'h01, Sub=1 -> Sum=8'hFF, Cout=0, Ovf=0. Cin=1 must not change either result.
- Handshake: a start pulse at cycle 3 of RUN is ignored, with Sum unchanged until done. A start asserted on the done cycle is accepted, and the second done follows 8 cycles later. Sum is stable between dones.
- Reset mid-op: drop rst_n asynchronously at the 4th RUN cycle -> outputs 0 immediately and no done. After release, A=8'h10, B=8'h20 -> Sum=8'h30.
- Parameter sweep:
  - WIDTH=16, SLICE=4: 16'h7FFF+16'h0001 -> Sum=16'h8000, Ovf=1, latency 4.
  - WIDTH=8, SLICE=8: latency 1.
  - Random 10k vectors checked against A+B+Cin and A-B.
